pipe_stage_chain: RTL and testbench
===================================

# pipe_stage_chain

Parametrised elastic pipeline register chain: successor to the fixed, always-enabled PLR_IFID/PLR_IDEX/PipelineReg stage registers in the five-stage cpu. It carries a WIDTH-bit payload through DEPTH register stages. Each stage has a valid bit, and the chain uses valid/ready handshakes at both ends. A per-stage flush mask kills younger stages on branch redirect. Occupancy and stall counters are exported for the hazard unit and for performance debug.

## Interface
- WIDTH, 16, payload bits per stage (>=1)
- DEPTH, 3, number of register stages (>=1); stage 0 is youngest (input side), stage DEPTH-1 drives the output
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  producer offers in_data
- in_data  input  WIDTH  payload
- in_ready  output  1  chain accepts in_data this cycle; handshake = in_valid & in_ready
- out_valid  output  1  stage DEPTH-1 holds a live item
- out_data  output  WIDTH  payload of stage DEPTH-1; meaningful only when out_valid=1
- out_ready  input  1  consumer takes item; handshake = out_valid & out_ready
- flush  input  DEPTH  bit i kills the item currently in stage i at this edge
- occupancy  output  $clog2(DEPTH+1)  registered count of valid stages (pre-flush)
- stall_cnt  output  16  saturating count of cycles with out_valid & ~out_ready

## Operation
- State: v[i] (valid) and d[i] (data) for i = 0..DEPTH-1.
- Live valid: lv[i] = v[i] & ~flush[i]. A flushed item is never delivered and never moves downstream.
- out_valid = lv[DEPTH-1]; out_data = d[DEPTH-1]. Flush reaches out_valid combinationally.
- Slot acceptance (collapse mode): acc[DEPTH-1] = ~lv[DEPTH-1] | out_ready; acc[i] = ~lv[i] | acc[i+1]; in_ready = acc[0] & ~rst.
- Slot acceptance (global-stall mode): en = ~(lv[DEPTH-1] & ~out_ready); acc[i] = en for all i; in_ready = en & ~rst.
- Per edge, when acc[i] is true: v[i] <= source valid, where the source is lv[i-1], or in_valid for i=0.
- Per edge, when acc[i] is false: v[i] <= lv[i].
- d[i] loads only when acc[i] is true and the source is valid. Otherwise d[i] holds.
- Items never reorder, duplicate, or drop, except by flush.
- flush does not affect the in_data accepted in the same cycle; that item enters stage 0 live.
- occupancy <= popcount of next v.
- stall_cnt increments when out_valid & ~out_ready and saturates at 16'hFFFF. Only rst clears it.

## Timing
- Reset, effective the edge rst is sampled high:
  - all v=0 and all d=0
  - out_valid=0, out_data=0, occupancy=0, stall_cnt=0
  - in_ready is held 0 while rst=1, and inputs are ignored
- Reset mid-operation discards all in-flight items. There is no drain.
- Latency: an item handshaken at cycle k into an empty chain shows out_valid at cycle k+DEPTH.
- Throughput: one item per cycle with out_ready=1.
- Full chain with out_ready=1: the output handshake and an input handshake occur in the same cycle, and occupancy stays at DEPTH.
- Full chain with out_ready=0: in_ready=0 in both modes.
- A flush on a full chain frees the flushed slots in that same cycle. In collapse mode, in_ready may therefore rise combinationally.
- DEPTH=1: in_ready = ~lv[0] | out_ready. This behaves as a single skid-less register.

## Configuration
- PIPE_COLLAPSE_EN defined: collapse mode. Bubbles compress; an item advances into any empty downstream slot while the output is stalled.
- PIPE_COLLAPSE_EN undefined: global-stall mode. All stages freeze together whenever stage DEPTH-1 is live and out_ready=0, which matches the lockstep behaviour of the legacy cpu pipeline registers.
- Interface and reset behaviour are identical in both modes.

## Test plan
All tests use WIDTH=16 and DEPTH=3.
- Stream: after reset, push 0x0001..0x0005 on consecutive cycles with out_ready=1 -> first out_valid in cycle 3, data 0x0001..0x0005 in order, occupancy steady at 3, in_ready constantly 1.
- Backpressure: out_ready=0, in_valid=1 with 0xA000+n -> exactly 3 accepts, then in_ready=0, occupancy=3, stall_cnt +1 per stalled cycle; then out_ready=1 -> 0xA000, 0xA001, 0xA002 emitted in order.
- Bubble: push A at cycle 0, idle at cycle 1, push B at cycle 2, out_ready=0 throughout ->
  - with PIPE_COLLAPSE_EN: B is in stage 1 at cycle 4, in_ready=1, and C is accepted.
  - without PIPE_COLLAPSE_EN: B stays in stage 0 and in_ready=0 from cycle 3.
- Branch flush: chain holds A(s2), B(s1), C(s0); flush=3'b011, out_ready=1, in_valid with D -> A delivered, B and C never appear, occupancy=1 next cycle, D is out_valid 2 cycles later.
- Output kill: stage 2 valid and out_ready=1, flush=3'b100 -> out_valid=0 in the same cycle, no handshake, item gone next cycle.
- Mid-stream reset: full chain, stall_cnt=5, rst high for one cycle -> in_ready=0 during rst; next cycle out_valid=0, occupancy=0, stall_cnt=0, out_data=0.

Source files
------------

// File: rtl/pipe_stage_chain_if.sv
// Producer/consumer handshake, per-stage flush mask and status counters for pipe_stage_chain.
// master drives the chain's inputs; slave is the chain itself.
interface pipe_stage_chain_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 3
);
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic [DEPTH-1:0] flush;
   logic [OCC_W-1:0] occupancy;
   logic [15:0]      stall_cnt;

   modport master (
      output in_valid, in_data, out_ready, flush,
      input  in_ready, out_valid, out_data, occupancy, stall_cnt
   );

   modport slave (
      input  in_valid, in_data, out_ready, flush,
      output in_ready, out_valid, out_data, occupancy, stall_cnt
   );
endinterface

// File: rtl/pipe_stage_chain.sv
// Elastic WIDTH x DEPTH valid/ready register chain with per-stage flush; DEPTH-cycle latency, 1 item/cycle.
// Backpressure: with PIPE_COLLAPSE_EN bubbles compress under stall, otherwise every stage freezes together.
module pipe_stage_chain #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 3
) (
   input logic               clk,
   input logic               rst,
   pipe_stage_chain_if.slave bus
);
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0]            v;
   logic [DEPTH-1:0]            lv;
   logic [DEPTH-1:0]            acc;
   logic [DEPTH-1:0]            src_v;
   logic [DEPTH-1:0]            v_nxt;
   logic [DEPTH-1:0][WIDTH-1:0] d;
   logic [DEPTH-1:0][WIDTH-1:0] src_d;
   logic [OCC_W-1:0]            occ_nxt;
   logic [OCC_W-1:0]            occupancy;
   logic [15:0]                 stall_cnt;

   // A flushed item is dead this cycle: it neither leaves nor advances.
   assign lv = v & ~bus.flush;

`ifdef PIPE_COLLAPSE_EN
   always_comb begin
      acc = '0;
      acc[DEPTH-1] = ~lv[DEPTH-1] | bus.out_ready;
      for (int i = DEPTH - 2; i >= 0; i--) begin
         acc[i] = ~lv[i] | acc[i+1];
      end
   end
`else
   logic en;
   assign en  = ~(lv[DEPTH-1] & ~bus.out_ready);
   assign acc = {DEPTH{en}};
`endif

   always_comb begin
      src_v    = '0;
      src_d    = '0;
      v_nxt    = '0;
      occ_nxt  = '0;
      src_v[0] = bus.in_valid;
      src_d[0] = bus.in_data;
      for (int i = 1; i < DEPTH; i++) begin
         src_v[i] = lv[i-1];
         src_d[i] = d[i-1];
      end
      for (int i = 0; i < DEPTH; i++) begin
         v_nxt[i] = acc[i] ? src_v[i] : lv[i];
         occ_nxt  = occ_nxt + OCC_W'(v_nxt[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v         <= '0;
         d         <= '0;
         occupancy <= '0;
         stall_cnt <= '0;
      end else begin
         v         <= v_nxt;
         occupancy <= occ_nxt;
         for (int i = 0; i < DEPTH; i++) begin
            if (acc[i] && src_v[i]) begin
               d[i] <= src_d[i];
            end
         end
         if (lv[DEPTH-1] && !bus.out_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end

   assign bus.in_ready  = acc[0] & ~rst;
   assign bus.out_valid = lv[DEPTH-1];
   assign bus.out_data  = d[DEPTH-1];
   assign bus.occupancy = occupancy;
   assign bus.stall_cnt = stall_cnt;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain (WIDTH=16, DEPTH=3): directed vector tables plus random traffic against a slot model.
module tb_pipe_stage_chain;
   localparam int WIDTH = 16;
   localparam int DEPTH = 3;
`ifdef PIPE_COLLAPSE_EN
   localparam bit COLLAPSE = 1'b1;
`else
   localparam bit COLLAPSE = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipe_stage_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
   pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic        iv;
      logic [15:0] id;
      logic        ordy;
      logic [2:0]  fl;
      logic        ir;
      logic        ov;
      logic [15:0] od;
      int          occ;
      int          st;
   } vec_t;

   vec_t tbl[$];
   int   n_chk = 0;
   int   n_err = 0;

   // Slot model: -1 marks an empty slot, otherwise the payload value.
   int   m[DEPTH];
   int   f[DEPTH];
   int   nx[DEPTH];
   int   e_stall;
   logic e_ir, e_ov;
   int   e_od;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic row(input logic iv, input logic [15:0] id, input logic ordy, input logic [2:0] fl,
                      input logic ir, input logic ov, input logic [15:0] od, input int occ, input int st);
      vec_t r;
      r.iv = iv; r.id = id; r.ordy = ordy; r.fl = fl;
      r.ir = ir; r.ov = ov; r.od = od; r.occ = occ; r.st = st;
      tbl.push_back(r);
   endtask

   task automatic drive(input logic iv, input logic [15:0] id, input logic ordy, input logic [2:0] fl);
      bus.in_valid  = iv;
      bus.in_data   = id;
      bus.out_ready = ordy;
      bus.flush     = fl;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_table(input string name);
      string s;
      foreach (tbl[k]) begin
         s = $sformatf("%s[%0d]", name, k);
         drive(tbl[k].iv, tbl[k].id, tbl[k].ordy, tbl[k].fl);
         check({s, ".in_ready"}, 32'(bus.in_ready), 32'(tbl[k].ir));
         check({s, ".out_valid"}, 32'(bus.out_valid), 32'(tbl[k].ov));
         if (tbl[k].ov) check({s, ".out_data"}, 32'(bus.out_data), 32'(tbl[k].od));
         check({s, ".occupancy"}, 32'(bus.occupancy), tbl[k].occ);
         check({s, ".stall_cnt"}, 32'(bus.stall_cnt), tbl[k].st);
         tick();
      end
      tbl.delete();
   endtask

   task automatic do_reset(input string name);
      rst = 1'b1;
      drive(1'b1, 16'hBEEF, 1'b1, 3'b000);
      check({name, ".rst_in_ready"}, 32'(bus.in_ready), 32'd0);
      tick();
      rst = 1'b0;
      drive(1'b0, 16'h0000, 1'b0, 3'b000);
      check({name, ".rst_out_valid"}, 32'(bus.out_valid), 32'd0);
      check({name, ".rst_out_data"}, 32'(bus.out_data), 32'd0);
      check({name, ".rst_occupancy"}, 32'(bus.occupancy), 32'd0);
      check({name, ".rst_stall_cnt"}, 32'(bus.stall_cnt), 32'd0);
      for (int i = 0; i < DEPTH; i++) m[i] = -1;
      e_stall = 0;
   endtask

   // Collapse: each item steps forward if the slot ahead ends up free; global: everything shifts or nothing does.
   task automatic model_eval(input logic iv, input int id, input logic ordy, input logic [DEPTH-1:0] fl);
      for (int i = 0; i < DEPTH; i++) begin
         f[i]  = fl[i] ? -1 : m[i];
         nx[i] = -1;
      end
      e_ov = (f[DEPTH-1] >= 0);
      e_od = f[DEPTH-1];
      if (COLLAPSE) begin
         if (e_ov && !ordy) nx[DEPTH-1] = f[DEPTH-1];
         for (int i = DEPTH - 2; i >= 0; i--) begin
            if (f[i] >= 0) begin
               if (nx[i+1] < 0) nx[i+1] = f[i];
               else nx[i] = f[i];
            end
         end
         e_ir = (nx[0] < 0);
      end else if (e_ov && !ordy) begin
         for (int i = 0; i < DEPTH; i++) nx[i] = f[i];
         e_ir = 1'b0;
      end else begin
         for (int i = 1; i < DEPTH; i++) nx[i] = f[i-1];
         e_ir = 1'b1;
      end
      if (e_ir && iv) nx[0] = id;
   endtask

   task automatic rnd_cyc(input int k);
      logic        iv, ordy;
      logic [15:0] id;
      logic [2:0]  fl;
      int          cnt;
      string       s;
      iv   = ($urandom_range(3) != 0);
      id   = 16'($urandom);
      ordy = ($urandom_range(2) != 0);
      fl   = ($urandom_range(7) == 0) ? 3'($urandom) : 3'b000;
      drive(iv, id, ordy, fl);
      model_eval(iv, int'(id), ordy, fl);
      cnt = 0;
      for (int i = 0; i < DEPTH; i++) if (m[i] >= 0) cnt++;
      s = $sformatf("rnd[%0d]", k);
      check({s, ".in_ready"}, 32'(bus.in_ready), 32'(e_ir));
      check({s, ".out_valid"}, 32'(bus.out_valid), 32'(e_ov));
      if (e_ov) check({s, ".out_data"}, 32'(bus.out_data), e_od);
      check({s, ".occupancy"}, 32'(bus.occupancy), cnt);
      check({s, ".stall_cnt"}, 32'(bus.stall_cnt), e_stall);
      @(posedge clk);
      if (e_ov && !ordy && e_stall < 65535) e_stall++;
      for (int i = 0; i < DEPTH; i++) m[i] = nx[i];
      @(negedge clk);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      bus.flush     = '0;
      do_reset("init");

      // Stream 1..5 at full rate.
      row(1, 16'h0001, 1, 3'b000, 1, 0, 16'h0000, 0, 0);
      row(1, 16'h0002, 1, 3'b000, 1, 0, 16'h0000, 1, 0);
      row(1, 16'h0003, 1, 3'b000, 1, 0, 16'h0000, 2, 0);
      row(1, 16'h0004, 1, 3'b000, 1, 1, 16'h0001, 3, 0);
      row(1, 16'h0005, 1, 3'b000, 1, 1, 16'h0002, 3, 0);
      row(0, 16'h0000, 1, 3'b000, 1, 1, 16'h0003, 3, 0);
      row(0, 16'h0000, 1, 3'b000, 1, 1, 16'h0004, 2, 0);
      row(0, 16'h0000, 1, 3'b000, 1, 1, 16'h0005, 1, 0);
      row(0, 16'h0000, 1, 3'b000, 1, 0, 16'h0000, 0, 0);
      // Backpressure: three accepts, then stall, then drain.
      row(1, 16'hA000, 0, 3'b000, 1, 0, 16'h0000, 0, 0);
      row(1, 16'hA001, 0, 3'b000, 1, 0, 16'h0000, 1, 0);
      row(1, 16'hA002, 0, 3'b000, 1, 0, 16'h0000, 2, 0);
      row(1, 16'hA003, 0, 3'b000, 0, 1, 16'hA000, 3, 0);
      row(1, 16'hA003, 0, 3'b000, 0, 1, 16'hA000, 3, 1);
      row(1, 16'hA003, 0, 3'b000, 0, 1, 16'hA000, 3, 2);
      row(0, 16'h0000, 1, 3'b000, 1, 1, 16'hA000, 3, 3);
      row(0, 16'h0000, 1, 3'b000, 1, 1, 16'hA001, 2, 3);
      row(0, 16'h0000, 1, 3'b000, 1, 1, 16'hA002, 1, 3);
      row(0, 16'h0000, 1, 3'b000, 1, 0, 16'h0000, 0, 3);
      // Branch flush of stages 0 and 1 while A leaves and D enters.
      row(1, 16'h00AA, 0, 3'b000, 1, 0, 16'h0000, 0, 3);
      row(1, 16'h00BB, 0, 3'b000, 1, 0, 16'h0000, 1, 3);
      row(1, 16'h00CC, 0, 3'b000, 1, 0, 16'h0000, 2, 3);
      row(1, 16'h00DD, 1, 3'b011, 1, 1, 16'h00AA, 3, 3);
      row(0, 16'h0000, 1, 3'b000, 1, 0, 16'h0000, 1, 3);
      row(0, 16'h0000, 1, 3'b000, 1, 0, 16'h0000, 1, 3);
      row(0, 16'h0000, 1, 3'b000, 1, 1, 16'h00DD, 1, 3);
      // Output kill: E flushed in the output stage.
      row(1, 16'h00EE, 1, 3'b000, 1, 0, 16'h0000, 0, 3);
      row(0, 16'h0000, 1, 3'b000, 1, 0, 16'h0000, 1, 3);
      row(0, 16'h0000, 1, 3'b000, 1, 0, 16'h0000, 1, 3);
      row(0, 16'h0000, 1, 3'b100, 1, 0, 16'h0000, 1, 3);
      row(0, 16'h0000, 1, 3'b000, 1, 0, 16'h0000, 0, 3);
      run_table("flow");

      do_reset("bubble");
`ifdef PIPE_COLLAPSE_EN
      row(1, 16'h0A0A, 0, 3'b000, 1, 0, 16'h0000, 0, 0);
      row(0, 16'h0000, 0, 3'b000, 1, 0, 16'h0000, 1, 0);
      row(1, 16'h0B0B, 0, 3'b000, 1, 0, 16'h0000, 1, 0);
      row(0, 16'h0000, 0, 3'b000, 1, 1, 16'h0A0A, 2, 0);
      row(1, 16'h0C0C, 0, 3'b000, 1, 1, 16'h0A0A, 2, 1);
      row(0, 16'h0000, 1, 3'b000, 1, 1, 16'h0A0A, 3, 2);
      row(0, 16'h0000, 1, 3'b000, 1, 1, 16'h0B0B, 2, 2);
      row(0, 16'h0000, 1, 3'b000, 1, 1, 16'h0C0C, 1, 2);
      row(0, 16'h0000, 1, 3'b000, 1, 0, 16'h0000, 0, 2);
`else
      row(1, 16'h0A0A, 0, 3'b000, 1, 0, 16'h0000, 0, 0);
      row(0, 16'h0000, 0, 3'b000, 1, 0, 16'h0000, 1, 0);
      row(1, 16'h0B0B, 0, 3'b000, 1, 0, 16'h0000, 1, 0);
      row(0, 16'h0000, 0, 3'b000, 0, 1, 16'h0A0A, 2, 0);
      row(1, 16'h0C0C, 0, 3'b000, 0, 1, 16'h0A0A, 2, 1);
      row(1, 16'h0C0C, 1, 3'b000, 1, 1, 16'h0A0A, 2, 2);
      row(0, 16'h0000, 1, 3'b000, 1, 0, 16'h0000, 2, 2);
      row(0, 16'h0000, 1, 3'b000, 1, 1, 16'h0B0B, 2, 2);
      row(0, 16'h0000, 1, 3'b000, 1, 1, 16'h0C0C, 1, 2);
      row(0, 16'h0000, 1, 3'b000, 1, 0, 16'h0000, 0, 2);
`endif
      run_table("bubble");

      do_reset("midrst");
      row(1, 16'h1111, 0, 3'b000, 1, 0, 16'h0000, 0, 0);
      row(1, 16'h2222, 0, 3'b000, 1, 0, 16'h0000, 1, 0);
      row(1, 16'h3333, 0, 3'b000, 1, 0, 16'h0000, 2, 0);
      row(0, 16'h0000, 0, 3'b000, 0, 1, 16'h1111, 3, 0);
      row(0, 16'h0000, 0, 3'b000, 0, 1, 16'h1111, 3, 1);
      row(0, 16'h0000, 0, 3'b000, 0, 1, 16'h1111, 3, 2);
      row(0, 16'h0000, 0, 3'b000, 0, 1, 16'h1111, 3, 3);
      row(0, 16'h0000, 0, 3'b000, 0, 1, 16'h1111, 3, 4);
      run_table("midrst");
      drive(1'b0, 16'h0000, 1'b0, 3'b000);
      check("midrst.pre_stall_cnt", 32'(bus.stall_cnt), 32'd5);
      check("midrst.pre_occupancy", 32'(bus.occupancy), 32'd3);
      do_reset("midrst");

      for (int k = 0; k < 800; k++) rnd_cyc(k);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
